// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell encodings, winning-line table,
// fallback move preference and the computer player's state set.
package ttt_pkg;

    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] X     = 2'b10;
    localparam logic [1:0] O     = 2'b11;

    localparam int         NUM_CELLS = 9;
    localparam int         NUM_LINES = 8;
    localparam logic [3:0] NO_CELL   = 4'b1111;

    // Rows, columns, then diagonals; this order is also the scan order.
    localparam logic [0:7][0:2][3:0] LINE_TABLE = '{
        '{4'd0, 4'd1, 4'd2},
        '{4'd3, 4'd4, 4'd5},
        '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6},
        '{4'd1, 4'd4, 4'd7},
        '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8},
        '{4'd2, 4'd4, 4'd6}
    };

    // Centre, corners, then edges.
    localparam logic [0:8][3:0] PICK_ORDER = '{
        4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
    };

    typedef enum logic [2:0] {
        IDLE,
        SCAN_WIN,
        SCAN_BLOCK,
        PICK,
        ISSUE,
        WAIT
    } aiState_t;

    function automatic logic [1:0] boardCell(input logic [17:0] board, input logic [3:0] idx);
        logic [17:0] shifted;
        shifted = board >> {idx, 1'b0};
        return shifted[1:0];
    endfunction

endpackage

// File: rtl/line_eval.sv
// Checks one winning line: hits when two cells hold the given symbol and
// the remaining cell is empty; hitPos names the empty position (0..2).
module line_eval
    import ttt_pkg::*;
(
    input  logic [1:0] cellA,
    input  logic [1:0] cellB,
    input  logic [1:0] cellC,
    input  logic [1:0] sym,
    output logic       hit,
    output logic [1:0] hitPos
);

    logic matchA, matchB, matchC;
    logic emptyA, emptyB, emptyC;

    assign matchA = (cellA == sym);
    assign matchB = (cellB == sym);
    assign matchC = (cellC == sym);
    assign emptyA = (cellA == EMPTY);
    assign emptyB = (cellB == EMPTY);
    assign emptyC = (cellC == EMPTY);

    always_comb begin
        hit    = 1'b0;
        hitPos = 2'd0;
        if (emptyA && matchB && matchC) begin
            hit    = 1'b1;
            hitPos = 2'd0;
        end else if (matchA && emptyB && matchC) begin
            hit    = 1'b1;
            hitPos = 2'd1;
        end else if (matchA && matchB && emptyC) begin
            hit    = 1'b1;
            hitPos = 2'd2;
        end
    end

endmodule

// File: rtl/ai_player.sv
// Computer opponent: snapshots the board on its turn, scans for a win, then a
// block, then falls back to a fixed preference, and writes exactly one move.
module ai_player
    import ttt_pkg::*;
#(
    parameter int ENABLE_WIN   = 1,
    parameter int ENABLE_BLOCK = 1
) (
    input  logic        ph1,
    input  logic        reset,
    input  logic        myTurn,
    input  logic [1:0]  mySymbol,
    input  logic [17:0] gBoard,
    input  logic        gameIsDone,
    output logic [3:0]  playerInput,
    output logic        playerWrite,
    output logic        busy
);

    aiState_t    state, stateNext;
    logic [2:0]  lineIdx, lineIdxNext;
    logic [17:0] snapshot, snapshotNext;
    logic [3:0]  chosenCell, chosenCellNext;

    logic        validSym;
    logic        abort;
    logic [1:0]  scanSym;
    logic [1:0]  cellA, cellB, cellC;
    logic        lineHit;
    logic [1:0]  hitPos;
    logic [3:0]  hitCell;
    logic [3:0]  pickCell;
    logic        pickFound;
    aiState_t    firstPhase, afterWin;

    assign validSym = (mySymbol == X) || (mySymbol == O);
    assign abort    = !myTurn || gameIsDone;
    assign scanSym  = (state == SCAN_BLOCK) ? (mySymbol ^ 2'b01) : mySymbol;
    assign busy     = (state != IDLE);

    // Disabled phases are skipped outright, so they cost no cycles.
    assign firstPhase = (ENABLE_WIN != 0)   ? SCAN_WIN   :
                        (ENABLE_BLOCK != 0) ? SCAN_BLOCK : PICK;
    assign afterWin   = (ENABLE_BLOCK != 0) ? SCAN_BLOCK : PICK;

    assign cellA = boardCell(snapshot, LINE_TABLE[lineIdx][0]);
    assign cellB = boardCell(snapshot, LINE_TABLE[lineIdx][1]);
    assign cellC = boardCell(snapshot, LINE_TABLE[lineIdx][2]);

    line_eval uLineEval (
        .cellA  (cellA),
        .cellB  (cellB),
        .cellC  (cellC),
        .sym    (scanSym),
        .hit    (lineHit),
        .hitPos (hitPos)
    );

    always_comb begin
        case (hitPos)
            2'd0:    hitCell = LINE_TABLE[lineIdx][0];
            2'd1:    hitCell = LINE_TABLE[lineIdx][1];
            default: hitCell = LINE_TABLE[lineIdx][2];
        endcase
    end

    // Walk the preference list backwards so the earliest empty entry wins.
    always_comb begin
        pickCell  = NO_CELL;
        pickFound = 1'b0;
        for (int i = NUM_CELLS - 1; i >= 0; i--) begin
            if (boardCell(snapshot, PICK_ORDER[i]) == EMPTY) begin
                pickCell  = PICK_ORDER[i];
                pickFound = 1'b1;
            end
        end
    end

    always_ff @(posedge ph1 or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lineIdx    <= 3'd0;
            snapshot   <= '0;
            chosenCell <= NO_CELL;
        end else begin
            state      <= stateNext;
            lineIdx    <= lineIdxNext;
            snapshot   <= snapshotNext;
            chosenCell <= chosenCellNext;
        end
    end

    always_comb begin
        stateNext      = state;
        lineIdxNext    = lineIdx;
        snapshotNext   = snapshot;
        chosenCellNext = chosenCell;
        playerWrite    = 1'b0;
        playerInput    = NO_CELL;

        case (state)
            IDLE: begin
                if (myTurn && !gameIsDone && validSym) begin
                    snapshotNext = gBoard;
                    lineIdxNext  = 3'd0;
                    stateNext    = firstPhase;
                end
            end
            SCAN_WIN, SCAN_BLOCK: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (lineHit) begin
                    chosenCellNext = hitCell;
                    stateNext      = ISSUE;
                end else if (lineIdx == 3'(NUM_LINES - 1)) begin
                    lineIdxNext = 3'd0;
                    stateNext   = (state == SCAN_WIN) ? afterWin : PICK;
                end else begin
                    lineIdxNext = lineIdx + 3'd1;
                end
            end
            PICK: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (pickFound) begin
                    chosenCellNext = pickCell;
                    stateNext      = ISSUE;
                end else begin
                    stateNext = WAIT;
                end
            end
            ISSUE: begin
                if (abort) begin
                    stateNext = IDLE;
                end else begin
                    playerWrite = 1'b1;
                    playerInput = chosenCell;
                    stateNext   = WAIT;
                end
            end
            WAIT: begin
                // Holding here until the turn ends keeps it to one write per turn.
                if (!myTurn) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ai_player.sv
// Directed bench for ai_player: win, block, preference, abort, reset,
// gameIsDone, full board, invalid symbol and snapshot behaviour.
module tb_ai_player;

    localparam logic [1:0] SX = 2'b10;
    localparam logic [1:0] SO = 2'b11;

    logic        ph1 = 1'b0;
    logic        reset = 1'b0;
    logic        myTurn = 1'b0;
    logic [1:0]  mySymbol = SX;
    logic [17:0] gBoard = '0;
    logic        gameIsDone = 1'b0;
    logic [3:0]  playerInput;
    logic        playerWrite;
    logic        busy;

    int checks = 0;
    int failures = 0;

    int          wCount;
    int          wCycle;
    logic [3:0]  wCell;
    int          dropAt = -1;
    int          doneAt = -1;
    int          swapAt = -1;
    int          markAt = -1;
    logic [17:0] swapBoard = '0;
    logic        markBusy;
    logic        markWrite;
    logic [3:0]  markInput;

    ai_player dut (
        .ph1         (ph1),
        .reset       (reset),
        .myTurn      (myTurn),
        .mySymbol    (mySymbol),
        .gBoard      (gBoard),
        .gameIsDone  (gameIsDone),
        .playerInput (playerInput),
        .playerWrite (playerWrite),
        .busy        (busy)
    );

    always #5 ph1 = ~ph1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [17:0] brd(input string s);
        logic [17:0] b;
        b = '0;
        for (int i = 0; i < 9; i++) begin
            if (s[i] == "X") b[2*i +: 2] = SX;
            else if (s[i] == "O") b[2*i +: 2] = SO;
        end
        return b;
    endfunction

    task automatic nextCycle();
        @(posedge ph1);
        #1;
    endtask

    task automatic sampleCycle(input int c);
        if (playerWrite === 1'b1) begin
            wCount++;
            wCycle = c;
            wCell  = playerInput;
        end
        if (c == markAt) begin
            markBusy  = busy;
            markWrite = playerWrite;
            markInput = playerInput;
        end
    endtask

    // Cycle 0 is the cycle in which myTurn is first seen high.
    task automatic runTurn(input int nCycles);
        wCount = 0;
        wCycle = -1;
        wCell  = 4'hF;
        markBusy  = 1'bx;
        markWrite = 1'bx;
        markInput = 4'hx;
        nextCycle();
        myTurn = 1'b1;
        #2;
        sampleCycle(0);
        for (int c = 1; c <= nCycles; c++) begin
            nextCycle();
            if (c == dropAt) myTurn = 1'b0;
            if (c == doneAt) gameIsDone = 1'b1;
            if (c == swapAt) gBoard = swapBoard;
            #2;
            sampleCycle(c);
        end
        nextCycle();
        myTurn = 1'b0;
        nextCycle();
        #2;
        dropAt = -1;
        doneAt = -1;
        swapAt = -1;
        markAt = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset state
        #3;
        check("rst_input", playerInput, 4'hF);
        check("rst_write", playerWrite, 1'b0);
        check("rst_busy", busy, 1'b0);
        nextCycle();
        reset = 1'b1;
        nextCycle();

        // Win on row 0, held turn must still give a single write
        mySymbol = SX;
        gBoard   = brd("XX..O...O");
        markAt   = 25;
        runTurn(25);
        check("win_count", wCount, 1);
        check("win_cycle", wCycle, 2);
        check("win_cell", wCell, 4'd2);
        check("win_wait_busy", markBusy, 1'b1);
        check("win_release_busy", busy, 1'b0);

        // Block on row 1
        mySymbol = SO;
        gBoard   = brd("O..XX....");
        runTurn(20);
        check("block_count", wCount, 1);
        check("block_cycle", wCycle, 11);
        check("block_cell", wCell, 4'd5);

        // Preference: empty board
        mySymbol = SX;
        gBoard   = brd(".........");
        runTurn(22);
        check("pref_empty_count", wCount, 1);
        check("pref_empty_cycle", wCycle, 18);
        check("pref_empty_cell", wCell, 4'd4);

        // Preference: centre taken
        gBoard = brd("....O....");
        runTurn(22);
        check("pref_corner_cycle", wCycle, 18);
        check("pref_corner_cell", wCell, 4'd0);

        // Preference: only cell 7 empty
        gBoard = brd("XOXXXOO.X");
        runTurn(22);
        check("pref_last_count", wCount, 1);
        check("pref_last_cycle", wCycle, 18);
        check("pref_last_cell", wCell, 4'd7);

        // Snapshot: board cleared after cycle 0 is ignored
        gBoard    = brd("XX..O...O");
        swapBoard = brd(".........");
        swapAt    = 1;
        runTurn(22);
        check("snap_cycle", wCycle, 2);
        check("snap_cell", wCell, 4'd2);

        // Abort: myTurn dropped in cycle 5
        gBoard = brd(".........");
        dropAt = 5;
        markAt = 6;
        runTurn(22);
        check("abort_count", wCount, 0);
        check("abort_busy", markBusy, 1'b0);

        // Reset asserted in cycle 12
        gBoard = brd(".........");
        wCount = 0;
        nextCycle();
        myTurn = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            nextCycle();
            #1;
            sampleCycle(c);
        end
        check("rstmid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("rstmid_input", playerInput, 4'hF);
        check("rstmid_write", playerWrite, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        myTurn = 1'b0;
        #1;
        reset = 1'b1;
        nextCycle();
        #2;
        check("rstmid_after_busy", busy, 1'b0);
        check("rstmid_count", wCount, 0);

        // gameIsDone already high when the turn starts
        gBoard     = brd(".........");
        gameIsDone = 1'b1;
        markAt     = 1;
        runTurn(22);
        check("done_start_count", wCount, 0);
        check("done_start_busy", markBusy, 1'b0);
        gameIsDone = 1'b0;

        // gameIsDone rising in the ISSUE cycle
        gBoard = brd("XX..O...O");
        doneAt = 2;
        markAt = 2;
        runTurn(10);
        check("done_issue_write", markWrite, 1'b0);
        check("done_issue_input", markInput, 4'hF);
        check("done_issue_count", wCount, 0);
        gameIsDone = 1'b0;

        // Full board: no write, waits for myTurn to fall
        gBoard = brd("XOXXOOOXX");
        markAt = 25;
        runTurn(25);
        check("full_count", wCount, 0);
        check("full_wait_busy", markBusy, 1'b1);
        check("full_release_busy", busy, 1'b0);

        // Invalid symbol never leaves IDLE
        mySymbol = 2'b01;
        gBoard   = brd(".........");
        markAt   = 3;
        runTurn(22);
        check("badsym_count", wCount, 0);
        check("badsym_busy", markBusy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ai_player.md
Name: ai_player

Overview:
- Computer opponent: the responder end of the player move interface that gameController consumes (playerInput/playerWrite).
- When signalled that it is its turn, it snapshots the 18-bit game board and scans the eight winning lines sequentially: first for a winning move, then for a blocking move, then by fixed preference.
- It then issues exactly one single-cycle write of the chosen cell.
- It replaces a human player; one or two instances can sit beside gameController.

Parameters:
- ENABLE_WIN, 1, 1 = run the win scan phase; 0 = skip it (zero cycles).
- ENABLE_BLOCK, 1, 1 = run the block scan phase; 0 = skip it (zero cycles).

Ports:
- ph1  input  1  single system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- myTurn  input  1  high while gameController is in this player's state.
- mySymbol  input  2  symbol played: X = 2'b10, O = 2'b11.
- gBoard  input  18  board; cell i at gBoard[2i+1:2i], cells 0..8 row-major; EMPTY = 2'b00.
- gameIsDone  input  1  game over; suppresses all activity.
- playerInput  output  4  chosen cell 0..8; 4'b1111 when not issuing.
- playerWrite  output  1  one-cycle move strobe.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: playerInput = 4'b1111, playerWrite = 0, busy = 0, state = IDLE, snapshot cleared. Reset is asynchronous and may occur mid-operation; the block returns to IDLE and no write issues.
- Opponent symbol is mySymbol ^ 2'b01. If mySymbol is 2'b00 or 2'b01, the block never leaves IDLE.
- Line table, in scan order:
  - L0 = {0,1,2}, L1 = {3,4,5}, L2 = {6,7,8} (rows)
  - L3 = {0,3,6}, L4 = {1,4,7}, L5 = {2,5,8} (columns)
  - L6 = {0,4,8}, L7 = {2,4,6} (diagonals)
- A line hits for symbol S when exactly two of its cells equal S and the third is EMPTY. The hit cell is that EMPTY cell.
- States: IDLE, SCAN_WIN, SCAN_BLOCK, PICK, ISSUE, WAIT.
- IDLE → SCAN_WIN: on a cycle where myTurn = 1 and gameIsDone = 0 (cycle 0). gBoard is latched into the snapshot. Line index resets to 0.
- SCAN_WIN evaluates one line per cycle against mySymbol; Lk is evaluated in cycle k+1.
  - First hit latches its cell and goes to ISSUE.
  - After L7 with no hit, go to SCAN_BLOCK.
- SCAN_BLOCK does the same against the opponent symbol in cycles 9..16.
  - Hit goes to ISSUE.
  - No hit after L7 goes to PICK.
- PICK (1 cycle) selects the first EMPTY cell in preference order 4, 0, 2, 6, 8, 1, 3, 5, 7, then goes to ISSUE.
  - If no cell is EMPTY, go to WAIT with no write.
- Worst-case latency: ISSUE in cycle 18 after the trigger. With a disabled phase, subtract 8 cycles per phase.
- ISSUE (1 cycle): playerWrite = 1 and playerInput = chosen cell, then go to WAIT. playerInput is 4'b1111 in all other states.
- WAIT holds until myTurn = 0, then goes to IDLE. This guarantees one write per turn, even if myTurn stays high.
- Abort rule: myTurn = 0 or gameIsDone = 1 in any of SCAN_WIN, SCAN_BLOCK, PICK or ISSUE forces the next state to IDLE, and playerWrite is suppressed in that same cycle.
- Only the snapshot is scanned. gBoard changes after cycle 0 are ignored.
- The chosen cell is always EMPTY in the snapshot.

Decomposition:
- Package ttt_pkg holds:
  - the cell state constants (EMPTY = 2'b00, X = 2'b10, O = 2'b11);
  - NUM_CELLS = 9 and NO_CELL = 4'b1111;
  - the 8×3 line-table constant;
  - the PICK preference-order constant;
  - the state enum.
- One combinational sub-module, line_eval:
  - inputs: three 2-bit cells and a 2-bit symbol;
  - outputs: hit, and hit position 0..2, which ai_player maps through the line table to a cell index.

Test Plan:
- Win: mySymbol = X; X on cells 0 and 1, O on 4 and 8, others empty; raise myTurn → playerWrite pulses in cycle 2 with playerInput = 2, once only.
- Block: mySymbol = O; X on 3 and 4, O on 0; all other cells empty → no win. Block hit on L1 in cycle 10 → ISSUE in cycle 11 with playerInput = 5.
- Preference: empty board, mySymbol = X → write in cycle 18 with cell 4. Center taken by O → cell 0. Board with only cell 7 empty and no hits → cell 7.
- Abort and reset: drop myTurn in cycle 5 → no write, busy = 0 next cycle. Separately, assert reset = 0 in cycle 12 → all outputs at reset values immediately.
- gameIsDone: gameIsDone = 1 when myTurn rises → stays IDLE, no write. gameIsDone rising in the ISSUE cycle → playerWrite stays 0.
- Full board or invalid mySymbol = 2'b01 → no playerWrite ever; WAIT releases to IDLE when myTurn falls.
